// File: rtl/scs8hd_pwrseq_pkg.sv
// Shared FSM encoding, registered-output decode and parameter defaults for the
// staged header-switch power sequencer.
package scs8hd_pwrseq_pkg;

  localparam int PWRSEQ_NUM_STAGES = 4;
  localparam int PWRSEQ_STAGE_DLY  = 8;
  localparam int PWRSEQ_ACK_TMO    = 64;
  localparam int TMR_W             = 10;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_RAMP     = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RESTORE  = 3'd3,
    ST_ON       = 3'd4,
    ST_ISO      = 3'd5,
    ST_SAVE     = 3'd6,
    ST_DOWN     = 3'd7
  } pwrseq_state_t;

  typedef struct packed {
    logic iso_en;
    logic dom_reset_b;
    logic pwr_ack;
    logic ret_save;
    logic ret_restore;
  } ctrl_t;

  // Domain controls are a pure function of the state being entered.
  function automatic ctrl_t ctrl_of(pwrseq_state_t s);
    ctrl_t c;
    c.iso_en      = (s != ST_ON);
    c.dom_reset_b = (s == ST_ON) || (s == ST_ISO) || (s == ST_SAVE);
    c.pwr_ack     = (s == ST_ON);
    c.ret_save    = (s == ST_SAVE);
    c.ret_restore = (s == ST_RESTORE);
    return c;
  endfunction

endpackage

// File: rtl/scs8hd_pwrseq_timer.sv
// Loadable 10-bit down-counter, saturating at zero; tc is high while the count is zero.
// Load takes effect on the next edge; no backpressure.
module scs8hd_pwrseq_timer
  import scs8hd_pwrseq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_b,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             tc
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/scs8hd_pwrseq_ctrl.sv
// Power-gating sequencer: staged switch ramp, ack wait with timeout, retention and isolation.
// All outputs registered; pwr_req is only sampled in OFF and ON, no other backpressure.
module scs8hd_pwrseq_ctrl
  import scs8hd_pwrseq_pkg::*;
#(
  parameter int NUM_STAGES = PWRSEQ_NUM_STAGES,
  parameter int STAGE_DLY  = PWRSEQ_STAGE_DLY,
  parameter int ACK_TMO    = PWRSEQ_ACK_TMO
) (
`ifdef SC_USE_PG_PIN
  input  logic                  vpwr,
  input  logic                  vgnd,
  input  logic                  vpb,
  input  logic                  vnb,
`endif
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  pwr_req,
  input  logic                  sw_ack,
  output logic [NUM_STAGES-1:0] sw_en,
  output logic                  iso_en,
  output logic                  ret_save,
  output logic                  ret_restore,
  output logic                  dom_reset_b,
  output logic                  pwr_ack,
  output logic                  timeout_err,
  output logic [2:0]            state_o
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply1 vpb;
  supply0 vgnd;
  supply0 vnb;
`endif

  localparam logic [TMR_W-1:0] STG_LD = TMR_W'(STAGE_DLY - 1);
  localparam logic [TMR_W-1:0] ACK_LD = TMR_W'(ACK_TMO - 1);

  // Sequencer is held in reset whenever its own rails are not valid.
  logic rst_n;
  assign rst_n = reset_b & vpwr & vpb & ~vgnd & ~vnb;

  pwrseq_state_t         state, nxt;
  logic [NUM_STAGES-1:0] sw_nxt;
  ctrl_t                 ctrl;
  logic                  tmr_load, tmr_tc, err_set;
  logic [TMR_W-1:0]      tmr_val;

  scs8hd_pwrseq_timer u_timer (
    .clk      (clk),
    .reset_b  (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    nxt      = state;
    sw_nxt   = sw_en;
    tmr_load = 1'b0;
    tmr_val  = STG_LD;
    err_set  = 1'b0;
    case (state)
      ST_OFF: begin
        if (pwr_req) begin
          nxt      = ST_RAMP;
          sw_nxt   = NUM_STAGES'(1);
          tmr_load = 1'b1;
        end
      end
      ST_RAMP: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          if (sw_en[NUM_STAGES-1]) begin
            nxt     = ST_WAIT_ACK;
            tmr_val = ACK_LD;
          end else begin
            sw_nxt = (sw_en << 1) | NUM_STAGES'(1);
          end
        end
      end
      ST_WAIT_ACK: begin
        if (sw_ack) begin
          nxt = ST_RESTORE;
        end else if (tmr_tc) begin
          err_set  = 1'b1;
          tmr_load = 1'b1;
          sw_nxt   = sw_en >> 1;
          nxt      = (sw_nxt == '0) ? ST_OFF : ST_DOWN;
        end
      end
      ST_RESTORE: nxt = ST_ON;
      ST_ON: begin
        if (!pwr_req) nxt = ST_ISO;
      end
      ST_ISO: nxt = ST_SAVE;
      // First stage drops on the same edge that enters DOWN.
      ST_SAVE: begin
        tmr_load = 1'b1;
        sw_nxt   = sw_en >> 1;
        nxt      = (sw_nxt == '0) ? ST_OFF : ST_DOWN;
      end
      ST_DOWN: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          sw_nxt   = sw_en >> 1;
          nxt      = (sw_nxt == '0) ? ST_OFF : ST_DOWN;
        end
      end
      default: nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      sw_en       <= '0;
      ctrl        <= ctrl_of(ST_OFF);
      timeout_err <= 1'b0;
    end else begin
      state <= nxt;
      sw_en <= sw_nxt;
      ctrl  <= ctrl_of(nxt);
      if (err_set) timeout_err <= 1'b1;
    end
  end

  assign iso_en      = ctrl.iso_en;
  assign dom_reset_b = ctrl.dom_reset_b;
  assign pwr_ack     = ctrl.pwr_ack;
  assign ret_save    = ctrl.ret_save;
  assign ret_restore = ctrl.ret_restore;
  assign state_o     = state;

endmodule

// File: tb/tb_scs8hd_pwrseq_ctrl.sv
// Bench for scs8hd_pwrseq_ctrl: directed vector table, corner sequences, and
// randomized traffic against a timeline reference model.
module tb_scs8hd_pwrseq_ctrl;

  localparam int N   = 4;
  localparam int D   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         reset_b = 1'b0;
  logic         pwr_req = 1'b0;
  logic         sw_ack = 1'b0;
  logic [N-1:0] sw_en;
  logic         iso_en, ret_save, ret_restore, dom_reset_b, pwr_ack, timeout_err;
  logic [2:0]   state_o;

  int n_chk = 0;
  int n_err = 0;

  scs8hd_pwrseq_ctrl dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .pwr_req     (pwr_req),
    .sw_ack      (sw_ack),
    .sw_en       (sw_en),
    .iso_en      (iso_en),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .dom_reset_b (dom_reset_b),
    .pwr_ack     (pwr_ack),
    .timeout_err (timeout_err),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          req;
    bit          ack;
    string       name;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] ev(int st, logic [3:0] sw, bit iso, bit drb, bit pk,
                                     bit sv, bit rs, bit er);
    return {st[2:0], sw, iso, drb, pk, sv, rs, er};
  endfunction

  function logic [12:0] obs();
    return {state_o, sw_en, iso_en, dom_reset_b, pwr_ack, ret_save, ret_restore, timeout_err};
  endfunction

  function automatic void add(int n, bit req, bit ack, string name, int st, logic [3:0] sw,
                              bit iso, bit drb, bit pk, bit sv, bit rs, bit er);
    vec_t v;
    v.n    = n;
    v.req  = req;
    v.ack  = ack;
    v.name = name;
    v.exp  = ev(st, sw, iso, drb, pk, sv, rs, er);
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [12:0] got, logic [12:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d sw=%b iso,drb,ack,sav,rst,err=%b required st=%0d sw=%b iso,drb,ack,sav,rst,err=%b",
               nm, got[12:10], got[9:6], got[5:0], exp[12:10], exp[9:6], exp[5:0]);
    end
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    pwr_req = 1'b0;
    sw_ack  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_b = 1'b1;
  endtask

  // Reference model: state codes with elapsed-cycle bookkeeping and a stage count.
  int m_st, m_stages, m_age;
  bit m_err;

  function void m_reset();
    m_st = 0; m_stages = 0; m_age = 0; m_err = 1'b0;
  endfunction

  function void m_step(bit req, bit ack);
    int a, ns;
    a  = m_age + 1;
    ns = m_st;
    case (m_st)
      0: if (req) begin ns = 1; m_stages = 1; end
      1: if (a % D == 0) begin
           if (m_stages == N) ns = 2;
           else m_stages++;
         end
      2: if (ack) ns = 3;
         else if (a == TMO) begin
           m_err = 1'b1;
           m_stages--;
           ns = (m_stages == 0) ? 0 : 7;
         end
      3: ns = 4;
      4: if (!req) ns = 5;
      5: ns = 6;
      6: begin m_stages--; ns = (m_stages == 0) ? 0 : 7; end
      default: if (a % D == 0) begin
           m_stages--;
           if (m_stages == 0) ns = 0;
         end
    endcase
    m_age = (ns != m_st) ? 0 : a;
    m_st  = ns;
  endfunction

  function logic [12:0] m_exp();
    return ev(m_st, 4'((1 << m_stages) - 1), m_st != 4, (m_st >= 4) && (m_st <= 6),
              m_st == 4, m_st == 6, m_st == 3, m_err);
  endfunction

  initial begin
    bit prev_sv, prev_rs, bad;
    int ack_pct;

    //   n  req ack name          st sw      iso drb pk sv rs er
    add(0,  0, 0, "reset",        0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(1,  1, 0, "up_c1",        1, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(7,  1, 0, "up_c8",        1, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1,  1, 0, "up_c9",        1, 4'b0011, 1, 0, 0, 0, 0, 0);
    add(8,  1, 0, "up_c17",       1, 4'b0111, 1, 0, 0, 0, 0, 0);
    add(8,  1, 0, "up_c25",       1, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(7,  1, 0, "up_c32",       1, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(1,  1, 0, "wait_c33",     2, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(6,  1, 0, "wait_c39",     2, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(1,  1, 1, "restore",      3, 4'b1111, 1, 0, 0, 0, 1, 0);
    add(1,  1, 0, "on",           4, 4'b1111, 0, 1, 1, 0, 0, 0);
    add(5,  1, 0, "on_hold",      4, 4'b1111, 0, 1, 1, 0, 0, 0);
    add(1,  0, 0, "iso",          5, 4'b1111, 1, 1, 0, 0, 0, 0);
    add(1,  0, 0, "save",         6, 4'b1111, 1, 1, 0, 1, 0, 0);
    add(1,  0, 0, "down_0111",    7, 4'b0111, 1, 0, 0, 0, 0, 0);
    add(7,  0, 0, "down_hold",    7, 4'b0111, 1, 0, 0, 0, 0, 0);
    add(1,  0, 0, "down_0011",    7, 4'b0011, 1, 0, 0, 0, 0, 0);
    add(8,  0, 0, "down_0001",    7, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(7,  0, 0, "down_last",    7, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(1,  0, 0, "off",          0, 4'b0000, 1, 0, 0, 0, 0, 0);
    add(1,  1, 0, "tmo_ramp",     1, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(32, 1, 0, "tmo_wait",     2, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(63, 0, 0, "tmo_c63",      2, 4'b1111, 1, 0, 0, 0, 0, 0);
    add(1,  0, 0, "tmo_c64",      7, 4'b0111, 1, 0, 0, 0, 0, 1);
    add(24, 0, 0, "tmo_off",      0, 4'b0000, 1, 0, 0, 0, 0, 1);
    add(1,  1, 0, "retry",        1, 4'b0001, 1, 0, 0, 0, 0, 1);
    add(8,  1, 0, "retry_0011",   1, 4'b0011, 1, 0, 0, 0, 0, 1);

    do_reset();
    foreach (vecs[i]) begin
      pwr_req = vecs[i].req;
      sw_ack  = vecs[i].ack;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk(vecs[i].name, obs(), vecs[i].exp);
    end

    // Asynchronous reset mid-ramp: outputs must drop with no clock edge.
    #2 reset_b = 1'b0;
    #1 chk("arst_now", obs(), ev(0, 4'b0000, 1, 0, 0, 0, 0, 0));
    pwr_req = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold", obs(), ev(0, 4'b0000, 1, 0, 0, 0, 0, 0));
    #2 reset_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("arst_off", obs(), ev(0, 4'b0000, 1, 0, 0, 0, 0, 0));

    // pwr_req toggled during the ramp must not disturb it.
    pwr_req = 1'b1;
    @(posedge clk); #1;
    chk("tog_c1", obs(), ev(1, 4'b0001, 1, 0, 0, 0, 0, 0));
    pwr_req = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("tog_c11", obs(), ev(1, 4'b0011, 1, 0, 0, 0, 0, 0));
    pwr_req = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("tog_c17", obs(), ev(1, 4'b0111, 1, 0, 0, 0, 0, 0));
    repeat (16) @(posedge clk); #1;
    chk("tog_c33", obs(), ev(2, 4'b1111, 1, 0, 0, 0, 0, 0));
    sw_ack = 1'b1;
    @(posedge clk); #1;
    chk("tog_restore", obs(), ev(3, 4'b1111, 1, 0, 0, 0, 1, 0));
    sw_ack = 1'b0;
    @(posedge clk); #1;
    chk("tog_on", obs(), ev(4, 4'b1111, 0, 1, 1, 0, 0, 0));

    // Randomized traffic against the reference model plus output invariants.
    do_reset();
    m_reset();
    prev_sv = 1'b0;
    prev_rs = 1'b0;
    ack_pct = 20;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 63) == 0) pwr_req = ~pwr_req;
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 0;
          1:       ack_pct = 5;
          default: ack_pct = 50;
        endcase
      end
      sw_ack = ($urandom_range(0, 99) < ack_pct);
      @(posedge clk);
      m_step(pwr_req, sw_ack);
      #1;
      chk($sformatf("rand_c%0d", c), obs(), m_exp());
      bad = (ret_save && ret_restore) || (ret_save && prev_sv) || (ret_restore && prev_rs)
         || (pwr_ack != (state_o == 3'd4)) || (iso_en == (state_o == 3'd4))
         || (dom_reset_b != ((state_o >= 3'd4) && (state_o <= 3'd6)));
      n_chk++;
      if (bad) begin
        n_err++;
        $display("FAIL inv_c%0d: st=%0d iso=%b drb=%b ack=%b sav=%b rst=%b prev_sav=%b prev_rst=%b required consistent controls",
                 c, state_o, iso_en, dom_reset_b, pwr_ack, ret_save, ret_restore, prev_sv, prev_rs);
      end
      prev_sv = ret_save;
      prev_rs = ret_restore;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/scs8hd_pwrseq_ctrl.md
SCS8HD_PWRSEQ_CTRL -- requirements
Module: scs8hd_pwrseq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 4, giving the number of staged header-switch enables for the gated domain.
REQ-002 The block SHALL have parameter STAGE_DLY, default 8, giving the cycles between successive switch-stage changes, legal range 1..255.
REQ-003 The block SHALL have parameter ACK_TMO, default 64, giving the maximum cycles to wait for sw_ack, legal range 1..1023.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset_b, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port pwr_req, input, 1 bit: level request, 1 = domain on, 0 = domain off.
REQ-007 The block SHALL have port sw_ack, input, 1 bit: switch-chain feedback, 1 = last stage conducting.
REQ-008 The block SHALL have port sw_en, output, NUM_STAGES bits: header-switch stage enables, bit 0 first on.
REQ-009 The block SHALL have ports iso_en, ret_save, ret_restore, dom_reset_b, pwr_ack and timeout_err, each output, 1 bit: isolation clamp, retention save pulse, retention restore pulse, domain reset (active-low), domain-on acknowledge, and sticky timeout flag.
REQ-010 The block SHALL have port state_o, output, 3 bits: current FSM state code.
REQ-011 The block SHALL have ports vpwr, vgnd, vpb and vnb, each input, 1 bit, present only when SC_USE_PG_PIN is defined, and SHALL declare them as supply1/supply0 nets otherwise.

Function
REQ-012 The FSM SHALL use the state codes OFF=0, RAMP=1, WAIT_ACK=2, RESTORE=3, ON=4, ISO=5, SAVE=6 and DOWN=7.
REQ-013 OFF: when pwr_req=1 is sampled, the block SHALL go to RAMP and set sw_en[0]=1 on the same edge.
REQ-014 RAMP: the block SHALL set sw_en[i] exactly i*STAGE_DLY cycles after sw_en[0], and SHALL go to WAIT_ACK STAGE_DLY cycles after sw_en[NUM_STAGES-1] is set.
REQ-015 WAIT_ACK: when sw_ack=1 is sampled, the block SHALL go to RESTORE; if ACK_TMO cycles elapse without sw_ack, it SHALL set timeout_err and go to DOWN.
REQ-016 RESTORE: the block SHALL hold ret_restore=1 for exactly one cycle and then go to ON; in ON it SHALL hold iso_en=0, dom_reset_b=1 and pwr_ack=1.
REQ-017 ON: when pwr_req=0 is sampled, the block SHALL go to ISO with iso_en=1 and pwr_ack=0 while dom_reset_b stays 1.
REQ-018 ISO SHALL last one cycle and then go to SAVE; SAVE SHALL hold ret_save=1 for one cycle and then go to DOWN with dom_reset_b=0.
REQ-019 DOWN: the block SHALL clear sw_en MSB-first, one stage every STAGE_DLY cycles starting on entry, and go to OFF on the edge where sw_en becomes all zero.
REQ-020 In every state other than ON, iso_en SHALL be 1, dom_reset_b SHALL be 0 except in ISO and SAVE, and pwr_ack SHALL be 0.
REQ-021 A pwr_req change during RAMP, WAIT_ACK, RESTORE, ISO, SAVE or DOWN SHALL be ignored; the block SHALL re-sample pwr_req only in OFF and ON.
REQ-022 ret_save and ret_restore SHALL never both be 1, and SHALL never be 1 for more than one consecutive cycle.
REQ-023 timeout_err SHALL be sticky and cleared only by reset; a later power-up attempt SHALL still be permitted.

Reset
REQ-024 While reset_b=0, the block SHALL force state OFF, sw_en=0, iso_en=1, dom_reset_b=0, ret_save=0, ret_restore=0, pwr_ack=0, timeout_err=0, and clear all counters, asynchronously.
REQ-025 Reset asserted mid-sequence SHALL drop all switch stages at once, with no staged ramp-down.

Structure
REQ-026 The shared package scs8hd_pwrseq_pkg SHALL hold the state encoding and the default values of NUM_STAGES, STAGE_DLY and ACK_TMO.
REQ-027 A single sub-module, scs8hd_pwrseq_timer, SHALL implement the loadable 10-bit down-counter with a terminal-count flag, used for the stage and timeout delays.

Verification
REQ-028 Defaults, pwr_req 0->1, sw_ack=1 at cycle 40: sw_en=0001/0011/0111/1111 at cycles 1/9/17/25; WAIT_ACK at cycle 33; RESTORE pulse next; ON with pwr_ack=1.
REQ-029 From ON, pwr_req 1->0: iso_en=1 next cycle; ret_save pulse one cycle later; dom_reset_b=0; sw_en=0111/0011/0001/0000 at 8-cycle spacing; then OFF.
REQ-030 sw_ack held 0: timeout_err=1 exactly 64 cycles after WAIT_ACK entry, staged ramp-down follows, and the next pwr_req=1 in OFF restarts RAMP.
REQ-031 pwr_req toggled 1->0->1 during RAMP: the ramp completes unchanged and the block reaches ON.
REQ-032 reset_b pulsed low in RAMP at sw_en=0011: outputs reach reset values without waiting for clk, and the block sits in OFF after release.
REQ-033 Randomized pwr_req and sw_ack over 10k cycles: assertions on REQ-020 and REQ-022 never fire.
